// File: rtl/dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// dm_access_arbiter
//
// Shares the single-port synchronous data memory between the pipeline EX/MEM
// stage and a debug / program-loader port.
//
//   * RUN  : the pipeline wins by default. A streak counter tracks consecutive
//            pipeline grants while debug is waiting. Once the streak reaches
//            MAX_STREAK, debug takes one slot and the pipeline is stalled for
//            that cycle.
//   * HALT : debug owns the memory exclusively and the pipeline is stalled.
//
// Grants and the memory mux are combinational from the current state and the
// requests. Read-valid strobes are registered one cycle after a read grant.
//
// Optional build macro: DM_ARB_STATS_EN
//   Adds saturating grant/stall statistics counters and their clear input.
//   Arbitration is identical with or without it.
// ---------------------------------------------------------------------------
module dm_access_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,

    // pipeline EX/MEM requester
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,

    // debug / loader requester
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_halt,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              halted,

`ifdef DM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_pipe_cnt,
    output logic [15:0]       stat_dbg_cnt,
    output logic [15:0]       stat_stall_cnt,
`endif

    // data memory port
    output logic              dm_en,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Streak limit in the counter's own width (legal range is 1..15)
    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_STREAK);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0] r_state;
    logic [3:0] r_streak;
    logic       r_pipe_rvalid;
    logic       r_dbg_rvalid;

    // -----------------------------------------------------------------------
    // Combinational arbitration results
    // -----------------------------------------------------------------------
    logic       w_pipe_gnt;
    logic       w_dbg_gnt;
    logic       w_stall;
    logic [0:0] w_state_nxt;
    logic [3:0] w_streak_nxt;
    logic       w_streak_full;

    assign w_streak_full = (r_streak == LP_MAX_STREAK);

    // Arbitration: decide who owns the memory this cycle and the next state
    always_comb begin
        w_pipe_gnt   = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_stall      = 1'b0;
        w_state_nxt  = r_state;
        w_streak_nxt = 4'd0;

        if (reset) begin
            // Nothing is granted and nothing is stalled while in reset
            w_pipe_gnt   = 1'b0;
            w_dbg_gnt    = 1'b0;
            w_stall      = 1'b0;
            w_state_nxt  = ST_RUN;
            w_streak_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (pipe_req && !(dbg_req && w_streak_full)) begin
                        // Pipeline wins; count the cycle only if debug is waiting
                        w_pipe_gnt = 1'b1;
                        if (dbg_req) begin
                            w_streak_nxt = r_streak + 4'd1;
                        end else begin
                            w_streak_nxt = 4'd0;
                        end
                    end else if (dbg_req) begin
                        // Debug wins either by starvation guard or by an idle
                        // pipeline; the pipeline only stalls if it was asking.
                        w_dbg_gnt    = 1'b1;
                        w_stall      = pipe_req;
                        w_streak_nxt = 4'd0;
                    end else begin
                        w_streak_nxt = 4'd0;
                    end

                    // Halt takes effect next cycle so an in-flight access completes
                    if (dbg_halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end

                ST_HALT: begin
                    // Pipeline frozen; debug may issue back-to-back accesses
                    w_stall      = 1'b1;
                    w_dbg_gnt    = dbg_req;
                    w_streak_nxt = 4'd0;
                    if (dbg_halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to RUN without granting
                    w_stall      = 1'b0;
                    w_streak_nxt = 4'd0;
                    w_state_nxt  = ST_RUN;
                end
            endcase
        end
    end

    // FSM, streak counter and read-valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_streak      <= 4'd0;
            r_pipe_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_streak      <= w_streak_nxt;
            r_pipe_rvalid <= w_pipe_gnt & ~pipe_we;
            r_dbg_rvalid  <= w_dbg_gnt & ~dbg_we;
        end
    end

    // -----------------------------------------------------------------------
    // Memory mux: debug and pipeline grants are mutually exclusive
    // -----------------------------------------------------------------------
    assign dm_en    = w_pipe_gnt | w_dbg_gnt;
    assign dm_we    = w_dbg_gnt ? dbg_we    : (w_pipe_gnt & pipe_we);
    assign dm_addr  = w_dbg_gnt ? dbg_addr  : pipe_addr;
    assign dm_wdata = w_dbg_gnt ? dbg_wdata : pipe_wdata;

    // -----------------------------------------------------------------------
    // Requester-facing outputs
    // -----------------------------------------------------------------------
    assign pipe_stall = w_stall;
    assign dbg_gnt    = w_dbg_gnt;
    assign halted     = (r_state == ST_HALT);

    // A read outstanding when reset rises must not surface as a valid, so the
    // registered strobes are also masked by reset in the reset cycle itself.
    assign pipe_rvalid = r_pipe_rvalid & ~reset;
    assign dbg_rvalid  = r_dbg_rvalid  & ~reset;

    // Both consumers see the memory output; each qualifies it with its rvalid
    assign pipe_rdata = dm_rdata;
    assign dbg_rdata  = dm_rdata;

`ifdef DM_ARB_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters (saturating)
    // -----------------------------------------------------------------------
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    logic [15:0] r_stat_pipe_cnt;
    logic [15:0] r_stat_dbg_cnt;
    logic [15:0] r_stat_stall_cnt;

    // Count grants and stall cycles; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            r_stat_pipe_cnt  <= 16'd0;
            r_stat_dbg_cnt   <= 16'd0;
            r_stat_stall_cnt <= 16'd0;
        end else begin
            if (w_pipe_gnt) begin
                r_stat_pipe_cnt <= sat_inc(r_stat_pipe_cnt);
            end else begin
                r_stat_pipe_cnt <= r_stat_pipe_cnt;
            end
            if (w_dbg_gnt) begin
                r_stat_dbg_cnt <= sat_inc(r_stat_dbg_cnt);
            end else begin
                r_stat_dbg_cnt <= r_stat_dbg_cnt;
            end
            if (w_stall) begin
                r_stat_stall_cnt <= sat_inc(r_stat_stall_cnt);
            end else begin
                r_stat_stall_cnt <= r_stat_stall_cnt;
            end
        end
    end

    assign stat_pipe_cnt  = r_stat_pipe_cnt;
    assign stat_dbg_cnt   = r_stat_dbg_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_access_arbiter
//
// Directed bench for dm_access_arbiter with a small behavioural data memory
// (1-cycle read latency). Inputs are driven 1 time unit after the rising edge
// and outputs are sampled on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_dm_access_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              pipe_req;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;
    logic              pipe_rvalid;
    logic [DATA_W-1:0] pipe_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_halt;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              halted;
    logic              dm_en;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
`ifdef DM_ARB_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_pipe_cnt;
    logic [15:0]       stat_dbg_cnt;
    logic [15:0]       stat_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    dm_access_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_STREAK (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_req       (pipe_req),
        .pipe_we        (pipe_we),
        .pipe_addr      (pipe_addr),
        .pipe_wdata     (pipe_wdata),
        .pipe_stall     (pipe_stall),
        .pipe_rvalid    (pipe_rvalid),
        .pipe_rdata     (pipe_rdata),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_halt       (dbg_halt),
        .dbg_gnt        (dbg_gnt),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata),
        .halted         (halted),
`ifdef DM_ARB_STATS_EN
        .stat_clr       (stat_clr),
        .stat_pipe_cnt  (stat_pipe_cnt),
        .stat_dbg_cnt   (stat_dbg_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .dm_en          (dm_en),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata)
    );

    // Clock: period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory, 256 words
    logic [DATA_W-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        dm_rdata = 16'h0000;
    end
    always @(posedge clk) begin
        if (dm_en) begin
            if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;
            else       dm_rdata <= mem[dm_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: inputs may be changed after this returns
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Middle of a cycle: outputs are sampled after this returns
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- 1. reset with both requests pending ----------------
        reset      = 1'b1;
        pipe_req   = 1'b1;
        pipe_we    = 1'b0;
        pipe_addr  = 16'h0100;
        pipe_wdata = 16'h1111;
        dbg_req    = 1'b1;
        dbg_we     = 1'b0;
        dbg_addr   = 16'h0200;
        dbg_wdata  = 16'h2222;
        dbg_halt   = 1'b0;
`ifdef DM_ARB_STATS_EN
        stat_clr   = 1'b0;
`endif
        for (int c = 0; c < 3; c++) begin
            cyc();
            mid();
            chk("rst_dm_en",      {31'd0, dm_en},      32'd0);
            chk("rst_dbg_gnt",    {31'd0, dbg_gnt},    32'd0);
            chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
            chk("rst_halted",     {31'd0, halted},     32'd0);
        end

        // ---------------- 2. streak limit, pipeline cycles 0..3 --------------
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) cyc();
            mid();
            if (c == 4 || c == 9) begin
                chk("streak_dbg_gnt", {31'd0, dbg_gnt},    32'd1);
                chk("streak_stall",   {31'd0, pipe_stall}, 32'd1);
                chk("streak_addr",    {16'd0, dm_addr},    32'h0200);
            end else begin
                chk("streak_pipe_en",  {31'd0, dm_en},      32'd1);
                chk("streak_pipe_gnt", {31'd0, dbg_gnt},    32'd0);
                chk("streak_nostall",  {31'd0, pipe_stall}, 32'd0);
                chk("streak_pipe_adr", {16'd0, dm_addr},    32'h0100);
            end
            if (c == 1) chk("pipe_rvalid_c1", {31'd0, pipe_rvalid}, 32'd1);
            if (c == 5) begin
                chk("pipe_rvalid_c5", {31'd0, pipe_rvalid}, 32'd0);
                chk("dbg_rvalid_c5",  {31'd0, dbg_rvalid},  32'd1);
            end
        end

        // ---------------- 6. statistics after 10 cycles ----------------------
        cyc();
        pipe_req = 1'b0;
        dbg_req  = 1'b0;
`ifdef DM_ARB_STATS_EN
        stat_clr = 1'b1;
`endif
        mid();
        chk("idle_dm_en", {31'd0, dm_en}, 32'd0);
`ifdef DM_ARB_STATS_EN
        chk("stat_pipe",  {16'd0, stat_pipe_cnt},  32'd8);
        chk("stat_dbg",   {16'd0, stat_dbg_cnt},   32'd2);
        chk("stat_stall", {16'd0, stat_stall_cnt}, 32'd2);
`endif
        cyc();
`ifdef DM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        mid();
`ifdef DM_ARB_STATS_EN
        chk("stat_clr_pipe",  {16'd0, stat_pipe_cnt},  32'd0);
        chk("stat_clr_dbg",   {16'd0, stat_dbg_cnt},   32'd0);
        chk("stat_clr_stall", {16'd0, stat_stall_cnt}, 32'd0);
`endif

        // ---------------- 3. debug write then read, pipeline idle ------------
        cyc();
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 16'h0010;
        dbg_wdata = 16'hBEEF;
        mid();
        chk("dw_gnt",   {31'd0, dbg_gnt},    32'd1);
        chk("dw_en",    {31'd0, dm_en},      32'd1);
        chk("dw_we",    {31'd0, dm_we},      32'd1);
        chk("dw_addr",  {16'd0, dm_addr},    32'h0010);
        chk("dw_data",  {16'd0, dm_wdata},   32'hBEEF);
        chk("dw_stall", {31'd0, pipe_stall}, 32'd0);
        cyc();
        dbg_we = 1'b0;
        mid();
        chk("dr_gnt",    {31'd0, dbg_gnt},    32'd1);
        chk("dr_we",     {31'd0, dm_we},      32'd0);
        chk("dr_nowval", {31'd0, dbg_rvalid}, 32'd0);
        cyc();
        dbg_req = 1'b0;
        mid();
        chk("dr_rvalid",   {31'd0, dbg_rvalid},  32'd1);
        chk("dr_rdata",    {16'd0, dbg_rdata},   32'hBEEF);
        chk("dr_pipe_rv",  {31'd0, pipe_rvalid}, 32'd0);

        // ---------------- 4. halt with a pipeline read in flight -------------
        cyc();
        pipe_req  = 1'b1;
        pipe_we   = 1'b0;
        pipe_addr = 16'h0010;
        dbg_halt  = 1'b1;
        mid();
        chk("hN_en",     {31'd0, dm_en},      32'd1);
        chk("hN_addr",   {16'd0, dm_addr},    32'h0010);
        chk("hN_stall",  {31'd0, pipe_stall}, 32'd0);
        chk("hN_halted", {31'd0, halted},     32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            dbg_req  = 1'b1;
            dbg_we   = 1'b0;
            dbg_addr = 16'h0020 + 16'(k);
            mid();
            chk("h_halted", {31'd0, halted},     32'd1);
            chk("h_stall",  {31'd0, pipe_stall}, 32'd1);
            chk("h_gnt",    {31'd0, dbg_gnt},    32'd1);
            chk("h_addr",   {16'd0, dm_addr},    32'h0020 + 32'(k));
            if (k == 0) begin
                chk("h_pipe_rvalid", {31'd0, pipe_rvalid}, 32'd1);
                chk("h_pipe_rdata",  {16'd0, pipe_rdata},  32'hBEEF);
            end else begin
                chk("h_pipe_norv",   {31'd0, pipe_rvalid}, 32'd0);
                chk("h_dbg_rvalid",  {31'd0, dbg_rvalid},  32'd1);
            end
        end
        cyc();
        dbg_req  = 1'b0;
        dbg_halt = 1'b0;
        mid();
        chk("hx_stall",  {31'd0, pipe_stall}, 32'd1);
        chk("hx_halted", {31'd0, halted},     32'd1);
        chk("hx_en",     {31'd0, dm_en},      32'd0);
        chk("hx_dbg_rv", {31'd0, dbg_rvalid}, 32'd1);
        cyc();
        mid();
        chk("run_stall",  {31'd0, pipe_stall}, 32'd0);
        chk("run_halted", {31'd0, halted},     32'd0);
        chk("run_en",     {31'd0, dm_en},      32'd1);
        chk("run_addr",   {16'd0, dm_addr},    32'h0010);

        // ---------------- 5. reset kills an outstanding debug read -----------
        cyc();
        pipe_req = 1'b0;
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 16'h0010;
        mid();
        chk("r5_gnt", {31'd0, dbg_gnt}, 32'd1);
        cyc();
        dbg_req = 1'b0;
        reset   = 1'b1;
        mid();
        chk("r5_rv_in_reset", {31'd0, dbg_rvalid}, 32'd0);
        cyc();
        reset = 1'b0;
        mid();
        chk("r5_rv_after",    {31'd0, dbg_rvalid},  32'd0);
        chk("r5_prv_after",   {31'd0, pipe_rvalid}, 32'd0);
        cyc();
        mid();
        chk("r5_rv_later",    {31'd0, dbg_rvalid},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
